// File: rtl/q2a03_pkg.sv
// Shared Q2A03 constants and the sprite-DMA state encoding.
// The cycle length is common to the core, the DMA block and the APU frame counter.
package q2a03_pkg;

    localparam int          CYCLE_TICKS  = 12;
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] DMA_OAM_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        HALT      = 3'd2,
        ALIGN     = 3'd3,
        READ      = 3'd4,
        WRITE     = 3'd5
    } dma_state_t;

endpackage

// File: rtl/q2a03_oam_dma_if.sv
// Core-side and system-bus-side signals seen by the sprite-DMA arbiter.
// master = the arbiter, slave = core plus system bus.
interface q2a03_oam_dma_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rdwr;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_rdwr;
    logic [7:0]  bus_rd_data;

    modport master (
        input  cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data,
        output cpu_ready, bus_addr, bus_wr_data, bus_rdwr
    );

    modport slave (
        output cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data,
        input  cpu_ready, bus_addr, bus_wr_data, bus_rdwr
    );

endinterface

// File: rtl/q2a03_cycle_div.sv
// Free-running bus-cycle divider: cyc_end marks the last tick of each CPU cycle,
// parity alternates get (0) / put (1) cycles. Frozen while enable is low.
module q2a03_cycle_div
    import q2a03_pkg::*;
#(
    parameter int TICKS_PER_CYCLE = CYCLE_TICKS
) (
    input  logic G_clock,
    input  logic G_reset,
    input  logic enable,
    output logic cyc_end,
    output logic parity
);

    localparam int              TW   = (TICKS_PER_CYCLE > 2) ? $clog2(TICKS_PER_CYCLE) : 1;
    localparam logic [TW-1:0]   LAST = TW'(TICKS_PER_CYCLE - 1);

    logic [TW-1:0] tick;

    assign cyc_end = enable && (tick == LAST);

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            tick   <= '0;
            parity <= 1'b0;
        end else if (enable) begin
            if (tick == LAST) begin
                tick   <= '0;
                parity <= ~parity;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/q2a03_oam_dma.sv
// Sprite-DMA controller: a write to REG_ADDR stalls the core and copies page:00..FF
// to OAM_ADDR, one read/write cycle pair per byte, then hands the bus back.
module q2a03_oam_dma
    import q2a03_pkg::*;
#(
    parameter int          TICKS_PER_CYCLE = CYCLE_TICKS,
    parameter logic [15:0] REG_ADDR        = DMA_REG_ADDR,
    parameter logic [15:0] OAM_ADDR        = DMA_OAM_ADDR
) (
    input  logic                    G_clock,
    input  logic                    G_reset,
    input  logic                    ext_ready,
    q2a03_oam_dma_if.master         port,
    output logic                    cyc_end,
    output logic                    dma_active
);

    dma_state_t state;
    logic       parity;
    logic       halt;
    logic [7:0] page;
    logic [7:0] count;
    logic [7:0] data_lat;

    q2a03_cycle_div #(
        .TICKS_PER_CYCLE (TICKS_PER_CYCLE)
    ) u_div (
        .G_clock (G_clock),
        .G_reset (G_reset),
        .enable  (ext_ready),
        .cyc_end (cyc_end),
        .parity  (parity)
    );

    assign port.cpu_ready = ext_ready & ~halt;

    // Every state and halt change lands on a cycle boundary, so the core only
    // ever sees ready move between whole bus cycles.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state      <= IDLE;
            page       <= '0;
            count      <= '0;
            data_lat   <= '0;
            halt       <= 1'b0;
            dma_active <= 1'b0;
        end else if (cyc_end) begin
            case (state)
                IDLE: begin
                    if (!port.cpu_rdwr && port.cpu_addr == REG_ADDR) begin
                        page       <= port.cpu_wr_data;
                        state      <= HALT_WAIT;
                        dma_active <= 1'b1;
                    end
                end
                HALT_WAIT: begin
                    if (port.cpu_rdwr) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end
                end
                // parity is the current cycle's; a get-cycle HALT is followed by a put
                HALT:  state <= parity ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    data_lat <= port.bus_rd_data;
                    state    <= WRITE;
                end
                WRITE: begin
                    count <= count + 8'd1;
                    if (count == 8'hFF) begin
                        state      <= IDLE;
                        halt       <= 1'b0;
                        dma_active <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        port.bus_addr    = port.cpu_addr;
        port.bus_wr_data = port.cpu_wr_data;
        port.bus_rdwr    = port.cpu_rdwr;
        case (state)
            READ: begin
                port.bus_addr = {page, count};
                port.bus_rdwr = 1'b1;
            end
            WRITE: begin
                port.bus_addr    = OAM_ADDR;
                port.bus_wr_data = data_lat;
                port.bus_rdwr    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Bench for the sprite-DMA arbiter: a cycle-level CPU model plus a scoreboard of
// every stalled bus cycle (dummy, read, write) checked as the DUT ends each cycle.
module tb_q2a03_oam_dma;

    logic G_clock;
    logic G_reset;
    logic ext_ready;
    logic cyc_end;
    logic dma_active;

    q2a03_oam_dma_if port();

    q2a03_oam_dma dut (
        .G_clock    (G_clock),
        .G_reset    (G_reset),
        .ext_ready  (ext_ready),
        .port       (port),
        .cyc_end    (cyc_end),
        .dma_active (dma_active)
    );

    localparam logic [15:0] CPU_RD = 16'hC0DE;

    typedef struct {
        logic [15:0] addr;
        logic        rdwr;
        logic [7:0]  data;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   stall_cnt = 0;
    bit   mon_en = 1'b1;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'hA5;
    endfunction

    always_comb port.bus_rd_data = mem_byte(port.bus_addr);

    initial G_clock = 1'b0;
    always #5 G_clock = ~G_clock;

    // Scoreboard: every cycle that ends with the core stalled must match the queue head
    always @(negedge G_clock) begin
        if (G_reset === 1'b1 && cyc_end === 1'b1) begin
            cyc_n++;
            if (port.cpu_ready === 1'b0) begin
                stall_cnt++;
                if (mon_en) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra got addr=%h rdwr=%b want no stalled cycle",
                                 port.bus_addr, port.bus_rdwr);
                    end else begin
                        sb_e = exp_q.pop_front();
                        if (port.bus_addr !== sb_e.addr || port.bus_rdwr !== sb_e.rdwr ||
                            (sb_e.chk && port.bus_wr_data !== sb_e.data) || dma_active !== 1'b1) begin
                            bad++;
                            $display("FAIL sb_cycle got addr=%h rdwr=%b wdata=%h act=%b want addr=%h rdwr=%b wdata=%h act=1",
                                     port.bus_addr, port.bus_rdwr, port.bus_wr_data, dma_active,
                                     sb_e.addr, sb_e.rdwr, sb_e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        int n;
        n = 0;
        forever begin
            @(negedge G_clock);
            if (cyc_end === 1'b1) break;
            n++;
            if (n > 80) begin
                total++;
                bad++;
                $display("FAIL cycle_timeout got=no cyc_end want=cyc_end within 80 clocks");
                break;
            end
        end
        @(posedge G_clock);
        #1;
    endtask

    task automatic cpu_cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
        port.cpu_addr    = a;
        port.cpu_rdwr    = rw;
        port.cpu_wr_data = d;
        next_cycle();
    endtask

    task automatic align_trigger(input int trig_par);
        while ((cyc_n % 2) != trig_par) cpu_cyc(16'h8000, 1'b1, 8'h00);
    endtask

    task automatic run_dma(input logic [7:0] pg, input int pre_writes, input bit odd,
                           input bit retrig, input bit ext_pulse);
        int   iter;
        int   ext_at;
        exp_t e;
        align_trigger((int'(odd) + 1 + pre_writes) % 2);
        cpu_cyc(16'h4014, 1'b0, pg);
        for (int k = 0; k < pre_writes; k++) begin
            total++;
            if (port.cpu_ready !== 1'b1 || dma_active !== 1'b1) begin
                bad++;
                $display("FAIL pre_write_ready got ready=%b act=%b want ready=1 act=1",
                         port.cpu_ready, dma_active);
            end
            cpu_cyc(16'h01FD - 16'(k), 1'b0, 8'hA0 + 8'(k));
        end
        for (int d = 0; d < (odd ? 2 : 1); d++) begin
            e.addr = CPU_RD; e.rdwr = 1'b1; e.data = 8'h00; e.chk = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 256; c++) begin
            e.addr = {pg, 8'(c)}; e.rdwr = 1'b1; e.data = 8'h00; e.chk = 1'b0;
            exp_q.push_back(e);
            e.addr = 16'h2004; e.rdwr = 1'b0; e.data = mem_byte({pg, 8'(c)}); e.chk = 1'b1;
            exp_q.push_back(e);
        end
        stall_cnt = 0;
        port.cpu_addr = CPU_RD; port.cpu_rdwr = 1'b1; port.cpu_wr_data = 8'h00;
        total++;
        if (port.cpu_ready !== 1'b1 || dma_active !== 1'b1) begin
            bad++;
            $display("FAIL halt_read_ready got ready=%b act=%b want ready=1 act=1",
                     port.cpu_ready, dma_active);
        end
        next_cycle();
        total++;
        if (port.cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL halt_assert got ready=%b want 0", port.cpu_ready);
        end
        iter   = 0;
        ext_at = 21 + int'(odd);
        while (port.cpu_ready !== 1'b1 && iter < 700) begin
            if (retrig && iter == 10) begin
                port.cpu_addr = 16'h4014; port.cpu_rdwr = 1'b0; port.cpu_wr_data = 8'h07;
            end
            if (retrig && iter == 11) begin
                port.cpu_addr = CPU_RD; port.cpu_rdwr = 1'b1; port.cpu_wr_data = 8'h00;
            end
            if (ext_pulse && iter == ext_at) begin
                repeat (3) @(posedge G_clock);
                #1;
                ext_ready = 1'b0;
                #1;
                total++;
                if (port.bus_addr !== {pg, 8'd10} || port.bus_rdwr !== 1'b1 || port.cpu_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL freeze_start got addr=%h rdwr=%b ready=%b want addr=%h rdwr=1 ready=0",
                             port.bus_addr, port.bus_rdwr, port.cpu_ready, {pg, 8'd10});
                end
                repeat (30) @(posedge G_clock);
                #1;
                total++;
                if (port.bus_addr !== {pg, 8'd10} || cyc_end !== 1'b0) begin
                    bad++;
                    $display("FAIL freeze_hold got addr=%h cyc_end=%b want addr=%h cyc_end=0",
                             port.bus_addr, cyc_end, {pg, 8'd10});
                end
                ext_ready = 1'b1;
            end
            next_cycle();
            iter++;
        end
        total++;
        if (stall_cnt !== 513 + int'(odd)) begin
            bad++;
            $display("FAIL stall_len got=%0d want=%0d", stall_cnt, 513 + int'(odd));
        end
        total++;
        if (port.cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
            bad++;
            $display("FAIL dma_end got ready=%b act=%b want ready=1 act=0", port.cpu_ready, dma_active);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d left want=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int n;
        G_reset = 1'b0;
        ext_ready = 1'b1;
        port.cpu_addr = 16'h1234; port.cpu_rdwr = 1'b1; port.cpu_wr_data = 8'h5A;
        #23;
        total++;
        if (port.cpu_ready !== 1'b1 || cyc_end !== 1'b0 || dma_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got ready=%b cyc_end=%b act=%b want 1 0 0",
                     port.cpu_ready, cyc_end, dma_active);
        end
        total++;
        if (port.bus_addr !== 16'h1234 || port.bus_rdwr !== 1'b1 || port.bus_wr_data !== 8'h5A) begin
            bad++;
            $display("FAIL reset_mux got addr=%h rdwr=%b wdata=%h want 1234 1 5a",
                     port.bus_addr, port.bus_rdwr, port.bus_wr_data);
        end
        ext_ready = 1'b0;
        #1;
        total++;
        if (port.cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_ext got=%b want=0", port.cpu_ready);
        end
        ext_ready = 1'b1;
        @(negedge G_clock);
        G_reset = 1'b1;
        n = 0;
        do begin
            @(negedge G_clock);
            n++;
        end while (cyc_end !== 1'b1 && n < 40);
        total++;
        if (n !== 11) begin
            bad++;
            $display("FAIL first_cyc_end got=%0d want=11 clocks", n);
        end
        n = 0;
        do begin
            @(negedge G_clock);
            n++;
        end while (cyc_end !== 1'b1 && n < 40);
        total++;
        if (n !== 12) begin
            bad++;
            $display("FAIL cycle_period got=%0d want=12 clocks", n);
        end
        @(posedge G_clock);
        #1;
    endtask

    task automatic test_even_copy();
        run_dma(8'h02, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_odd_align();
        run_dma(8'h02, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_cpu_write_after_trigger();
        run_dma(8'h11, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_retrigger_ext_ready();
        run_dma(8'h02, 0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_copy();
        mon_en = 1'b0;
        align_trigger(1);
        cpu_cyc(16'h4014, 1'b0, 8'h03);
        port.cpu_addr = CPU_RD; port.cpu_rdwr = 1'b1; port.cpu_wr_data = 8'h00;
        next_cycle();
        repeat (129) next_cycle();
        total++;
        if (port.bus_addr !== 16'h0340 || port.bus_rdwr !== 1'b1) begin
            bad++;
            $display("FAIL mid_copy_addr got addr=%h rdwr=%b want 0340 1", port.bus_addr, port.bus_rdwr);
        end
        #3;
        G_reset = 1'b0;
        #1;
        total++;
        if (port.cpu_ready !== 1'b1 || dma_active !== 1'b0 || port.bus_addr !== CPU_RD || port.bus_rdwr !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got ready=%b act=%b addr=%h rdwr=%b want 1 0 %h 1",
                     port.cpu_ready, dma_active, port.bus_addr, port.bus_rdwr, CPU_RD);
        end
        port.cpu_addr = 16'h4321; port.cpu_rdwr = 1'b0; port.cpu_wr_data = 8'h9C;
        #1;
        total++;
        if (port.bus_addr !== 16'h4321 || port.bus_rdwr !== 1'b0 || port.bus_wr_data !== 8'h9C) begin
            bad++;
            $display("FAIL mid_reset_mux got addr=%h rdwr=%b wdata=%h want 4321 0 9c",
                     port.bus_addr, port.bus_rdwr, port.bus_wr_data);
        end
        port.cpu_addr = 16'h8000; port.cpu_rdwr = 1'b1; port.cpu_wr_data = 8'h00;
        cyc_n = 0;
        exp_q.delete();
        @(negedge G_clock);
        G_reset = 1'b1;
        mon_en = 1'b1;
        next_cycle();
        run_dma(8'h05, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_even_copy();
        test_odd_align();
        test_cpu_write_after_trigger();
        test_retrigger_ext_ready();
        test_reset_mid_copy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q2a03_oam_dma.md
Name: q2a03_oam_dma

Overview:
- Sprite-DMA controller and bus arbiter between the Q2A03 core and the system bus.
- A CPU write to the DMA register latches a source page. The block then stalls the core through its ready input and owns the bus.
- It copies 256 bytes from page:00..page:FF to the OAM data port, then returns the bus to the CPU.
- It owns a free-running bus-cycle divider that matches the core's 12-tick cycle, so every stall lasts an integral number of CPU cycles.

Parameters:
- TICKS_PER_CYCLE, 12, G_clock ticks per CPU bus cycle; must match the core.
- REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_ADDR, 16'h2004, destination address of every DMA write.

Ports:
- G_clock  in  1  system clock
- G_reset  in  1  asynchronous, active-low reset
- ext_ready  in  1  external ready; low freezes the divider and the FSM
- cpu_addr  in  16  core address
- cpu_wr_data  in  8  core write data
- cpu_rdwr  in  1  core direction, 1 = read
- cpu_ready  out  1  to the core's G_ready; ext_ready AND not-halted
- bus_addr  out  16  muxed system address
- bus_wr_data  out  8  muxed write data
- bus_rdwr  out  1  muxed direction
- bus_rd_data  in  8  system read data; also passed to the core
- cyc_end  out  1  one-clock pulse on the last tick of each bus cycle
- dma_active  out  1  high from trigger through the final write cycle

Behaviour:
- Reset values (G_reset asynchronous, active-low; clock G_clock): tick=0, parity=0, state=IDLE, page=0, count=0, data latch=0, cyc_end=0, dma_active=0, halt=0.
  - cpu_ready=ext_ready.
  - The bus mux selects the CPU.
- Divider:
  - tick increments while ext_ready=1 and wraps at TICKS_PER_CYCLE-1.
  - cyc_end=(tick==TICKS_PER_CYCLE-1)&&ext_ready.
  - parity toggles on every cyc_end; parity 0 is a get cycle, parity 1 is a put cycle.
- All FSM transitions, and all halt changes, occur only on cyc_end. cpu_ready therefore changes only at cycle boundaries.
- Trigger:
  - Condition: cyc_end while state==IDLE, cpu_rdwr=0 and cpu_addr==REG_ADDR.
  - Action: page<=cpu_wr_data, state<=HALT_WAIT, dma_active<=1.
  - Writes to REG_ADDR in any other state are ignored.
- HALT_WAIT: on cyc_end, if cpu_rdwr=1 then halt<=1 and the next state is HALT; otherwise stay. The core's write cycles are never stalled.
- HALT: one dummy cycle with the CPU's address on the bus. The next state is ALIGN if the next cycle is a put cycle, otherwise READ.
- ALIGN: one dummy cycle, then READ.
- Bus ownership: from READ onward the bus mux selects the DMA.
- READ:
  - bus_addr={page,count}, bus_rdwr=1.
  - On cyc_end: data latch<=bus_rd_data, next state WRITE.
- WRITE:
  - bus_addr=OAM_ADDR, bus_rdwr=0, bus_wr_data=data latch.
  - On cyc_end: count<=count+1, which wraps in 8 bits.
  - If count was FF: state<=IDLE, halt<=0, dma_active<=0. Otherwise state<=READ.
- Stall length: 513 cycles from the HALT cycle through the last WRITE when the DMA is even-aligned, 514 when odd-aligned.
- Outside READ and WRITE, bus_* equal cpu_* combinationally.
- cpu_ready=ext_ready&~halt at all times.
- ext_ready low: tick, parity and the FSM hold their values, and bus outputs hold.
- Reset mid-DMA returns everything to the reset state immediately; the partial copy is abandoned.
- A simultaneous trigger and cyc_end on the final WRITE is impossible, because the CPU is halted.

Decomposition:
- Package q2a03_pkg holds:
  - the dma_state_t enum: IDLE, HALT_WAIT, HALT, ALIGN, READ, WRITE;
  - the REG_ADDR and OAM_ADDR defaults;
  - the 12-tick cycle constant, also shared by the core.
- One natural sub-module, q2a03_cycle_div: the tick counter with cyc_end and parity outputs, reusable by the APU frame counter.

Test Plan:
- Even-aligned copy: CPU writes 8'h02 to 4014; the next CPU cycle is a read on parity 0.
  - cpu_ready is low for exactly 513 cycles.
  - 256 reads of 0200..02FF appear on the bus, each followed by a write to 2004 carrying the byte read.
  - dma_active falls with cpu_ready.
- Odd alignment: same trigger, but HALT falls on a get cycle, so the following cycle is a put. Required response: one ALIGN cycle and a 514-cycle stall.
- CPU write after trigger: the core performs two further write cycles, as in a push sequence. Both complete with cpu_ready high; the halt asserts only at the first read.
- Re-trigger ignored: a forced write to 4014 with 8'h07 during an active DMA leaves page at 02 and the 0200..02FF addresses unchanged.
- ext_ready pulse: hold ext_ready low for 30 clocks during a READ cycle. The divider and FSM freeze, and the total stall measured in cyc_end pulses is unchanged.
- Reset mid-copy: assert G_reset at count=8'h40.
  - cpu_ready=1, dma_active=0 and the bus mux selects the CPU immediately.
  - After release, a write to 4014 starts a fresh copy beginning at address XX00.
